// File: rtl/phase_timer.sv
// Washer phase timer: loads a per-phase tick duration, counts it down with a clock prescaler,
// and handles lid pause, abort, phase switching and illegal multi-phase requests.
module phase_timer #(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned SOAK_TICKS  = 20,
    parameter int unsigned WASH_TICKS  = 40,
    parameter int unsigned RINSE_TICKS = 20,
    parameter int unsigned SPIN_TICKS  = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        soak_Operation,
    input  logic        wash_Operation,
    input  logic        rinse_Operation,
    input  logic        spin_Operation,
    input  logic        mode_1,
    input  logic        mode_2,
    input  logic        mode_3,
    input  logic        lid,
    output logic        phase_Done,
    output logic [15:0] remaining,
    output logic        busy,
    output logic        phase_Error
);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    localparam logic [15:0] TickMax = 16'(TICK_DIV - 1);
    localparam int unsigned SpinHalf = ((SPIN_TICKS >> 1) == 0) ? 1 : (SPIN_TICKS >> 1);

    state_e      st_q, st_d;
    logic [1:0]  ph_q, ph_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] rem_q, rem_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [3:0]  req_vec;
    logic        req_none, req_multi;
    logic [1:0]  req_ph;
    logic [15:0] dur;
    logic        load;

    assign req_vec   = {spin_Operation, rinse_Operation, wash_Operation, soak_Operation};
    assign req_none  = (req_vec == 4'd0);
    assign req_multi = ((req_vec & (req_vec - 4'd1)) != 4'd0);

    always_comb begin
        req_ph = 2'd0;
        if (req_vec[1]) begin
            req_ph = 2'd1;
        end else if (req_vec[2]) begin
            req_ph = 2'd2;
        end else if (req_vec[3]) begin
            req_ph = 2'd3;
        end
    end

    // Mode priority 3 > 2 > 1; no mode bit behaves like mode 2 (base durations).
    always_comb begin
        dur = 16'(SOAK_TICKS);
        case (req_ph)
            2'd1: dur = mode_3 ? 16'(2 * WASH_TICKS) : 16'(WASH_TICKS);
            2'd2: dur = mode_3 ? 16'(2 * RINSE_TICKS) : 16'(RINSE_TICKS);
            2'd3: dur = (!mode_3 && !mode_2 && mode_1) ? 16'(SpinHalf) : 16'(SPIN_TICKS);
            default: dur = 16'(SOAK_TICKS);
        endcase
    end

    always_comb begin
        st_d    = st_q;
        ph_d    = ph_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = req_multi;
        load    = 1'b0;
        if (req_multi) begin
            st_d    = StIdle;
            rem_d   = 16'd0;
            presc_d = 16'd0;
        end else begin
            case (st_q)
                StIdle: begin
                    if (!req_none) begin
                        load = 1'b1;
                    end
                end
                StDone: begin
                    if (req_none) begin
                        st_d = StIdle;
                    end else if (req_ph != ph_q) begin
                        load = 1'b1;
                    end
                end
                StRun, StPaused: begin
                    // Abort and phase switch both outrank pause and expiry.
                    if (req_none) begin
                        st_d    = StIdle;
                        rem_d   = 16'd0;
                        presc_d = 16'd0;
                    end else if (req_ph != ph_q) begin
                        load = 1'b1;
                    end else if (lid) begin
                        st_d = StPaused;
                    end else begin
                        st_d = StRun;
                        if (presc_q == TickMax) begin
                            presc_d = 16'd0;
                            if (rem_q <= 16'd1) begin
                                rem_d  = 16'd0;
                                st_d   = StDone;
                                done_d = 1'b1;
                            end else begin
                                rem_d = rem_q - 16'd1;
                            end
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                end
                default: st_d = StIdle;
            endcase
        end
        if (load) begin
            ph_d    = req_ph;
            rem_d   = dur;
            presc_d = 16'd0;
            st_d    = lid ? StPaused : StRun;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q    <= StIdle;
            ph_q    <= 2'd0;
            presc_q <= 16'd0;
            rem_q   <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            ph_q    <= ph_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign phase_Done  = done_q;
    assign remaining   = rem_q;
    assign busy        = (st_q == StRun) || (st_q == StPaused);
    assign phase_Error = err_q;

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter TICK_DIV, default 1000: clock cycles per timer tick; legal range 1..65535.
REQ-002 Parameters SOAK_TICKS 20, WASH_TICKS 40, RINSE_TICKS 20, SPIN_TICKS 30: base phase durations in ticks; legal range 1..16383.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-005 soak_Operation, wash_Operation, rinse_Operation, spin_Operation  in  1 each  phase requests from the washer controller; legal input is one-hot or all-zero.
REQ-006 mode_1, mode_2, mode_3  in  1 each  program select, sampled only at load.
REQ-007 lid  in  1  1 = lid open; pauses counting.
REQ-008 phase_Done  out  1  one-cycle pulse when the active phase expires.
REQ-009 remaining  out  16  ticks left in the active phase.
REQ-010 busy  out  1  high in RUN and PAUSED.
REQ-011 phase_Error  out  1  registered; high while more than one phase input is high.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSED and DONE, plus a 2-bit register holding the loaded phase.
REQ-013 Load: in IDLE or DONE, when exactly one phase input is high and differs from the loaded phase (or the state is IDLE), the block SHALL load remaining with the duration, clear the prescaler and enter RUN at that edge.
REQ-014 Duration: mode priority is mode_3 > mode_2 > mode_1; no mode bit set counts as mode_2.
REQ-015 Mode_3 durations: wash = 2*WASH_TICKS, rinse = 2*RINSE_TICKS.
REQ-016 Mode_1 duration: spin = SPIN_TICKS>>1, with a minimum of 1.
REQ-017 All other mode/phase combinations SHALL use the base durations.
REQ-018 Prescaler: in RUN with lid=0 it SHALL count 0..TICK_DIV-1 and wrap to 0; each wrap is one tick, and each tick decrements remaining by 1.
REQ-019 Expiry: the tick that takes remaining from 1 to 0 SHALL move the FSM to DONE and assert phase_Done for exactly the next cycle. First pulse occurs D*TICK_DIV cycles after the load edge, where D is the loaded duration.
REQ-020 remaining SHALL never underflow below 0, and phase_Done SHALL never fire more than once per load.
REQ-021 Pause: lid=1 in RUN SHALL move the FSM to PAUSED at the next edge and freeze both the prescaler and remaining.
REQ-022 Resume: lid=0 in PAUSED SHALL return the FSM to RUN, and counting SHALL continue from the frozen prescaler value.
REQ-023 Abort: if the loaded phase input drops to 0 in RUN or PAUSED, the block SHALL go to IDLE, clear remaining to 0 and not pulse phase_Done.
REQ-024 Abort takes priority over pause and over expiry in the same cycle.
REQ-025 Phase switch mid-run: if a different single phase input becomes high in RUN or PAUSED, the block SHALL reload per REQ-013 and enter RUN (or PAUSED if lid=1) without pulsing phase_Done.
REQ-026 Error: if more than one phase input is high, the block SHALL set phase_Error, go to IDLE, clear remaining and ignore all loads until the inputs are legal again.
REQ-027 DONE SHALL hold remaining=0 until the phase inputs go all-zero (then IDLE) or change to a new single phase (then reload).
REQ-028 A lid=1 at the load edge SHALL load the duration and enter PAUSED directly.

Reset
REQ-029 While reset=1: state = IDLE, loaded phase = soak encoding, prescaler = 0, remaining = 0, phase_Done = 0, busy = 0, phase_Error = 0.
REQ-030 Reset asserted mid-phase SHALL abort with no phase_Done pulse.
REQ-031 After reset deasserts, a phase input already high SHALL load on the first clock edge.

Verification (bench parameters: TICK_DIV=4, SOAK 3, WASH 5, RINSE 2, SPIN 3)
REQ-032 Soak with mode_2 and lid=0 -> remaining sequence 3,2,1,0 at 4-cycle steps; phase_Done pulses once at 12 cycles after load, then the FSM holds in DONE.
REQ-033 Wash with mode_3 -> remaining loads 10; spin with mode_1 -> remaining loads 1.
REQ-034 Wash running, remaining=3, lid=1 for 7 cycles then 0 -> remaining holds 3; phase_Done arrives 7 cycles later than in the unpaused run.
REQ-035 Rinse running, rinse input drops at remaining=1 on the expiry tick -> IDLE, remaining=0, no phase_Done.
REQ-036 Soak and wash both high -> phase_Error=1 the next cycle and remaining=0; dropping to wash only -> phase_Error=0 and wash loads 5.
REQ-037 Reset pulsed mid-spin with the spin input held high -> all outputs zero during reset; after release, spin reloads to 3 with no spurious phase_Done.
